// File: rtl/seq_frame_accumulator.sv
// Frame-based running accumulator: add/sub/load/hold with wrap or saturate,
// emitting a frame result and DONE pulse every FRAME accepted samples.
module seq_frame_accumulator #(
    parameter  int WIDTH    = 8,
    parameter  int FRAME    = 8,
    parameter  int SATURATE = 0,
    localparam int CW       = $clog2(FRAME + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic [CW-1:0]    CNT,
    output logic             OVF,
    output logic             DONE,
    output logic [WIDTH-1:0] FRAME_SUM,
    output logic             FRAME_OVF
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] q_d, fsum_d, res;
    logic [CW-1:0]    cnt_d;
    logic             ovf_d, done_d, fovf_d;
    logic             accept, last, evt;
    logic [WIDTH:0]   sum, dif;

    assign sum    = {1'b0, Q} + {1'b0, A};
    assign dif    = {1'b0, Q} - {1'b0, A};
    assign accept = EN && (MODE != 2'b11);

    always_comb begin
        res = A;
        evt = 1'b0;
        unique case (1'b1)
            MODE == 2'b00: begin
                evt = sum[WIDTH];
                res = (SATURATE != 0 && evt) ? '1 : sum[WIDTH-1:0];
            end
            MODE == 2'b01: begin
                evt = dif[WIDTH];
                res = (SATURATE != 0 && evt) ? '0 : dif[WIDTH-1:0];
            end
            default: begin
                res = A;
                evt = 1'b0;
            end
        endcase
    end

    // With a single-sample frame every accepted sample completes it
    assign last = (FRAME == 1) ? 1'b1
                : (state == RUN && CNT == CW'(FRAME - 1));

    always_comb begin
        state_d = state;
        q_d     = Q;
        cnt_d   = CNT;
        ovf_d   = OVF;
        done_d  = 1'b0;
        fsum_d  = FRAME_SUM;
        fovf_d  = FRAME_OVF;
        if (CLR) begin
            state_d = IDLE;
            q_d     = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            if (last) begin
                state_d = IDLE;
                fsum_d  = res;
                fovf_d  = OVF | evt;
                q_d     = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                q_d     = res;
                cnt_d   = CNT + CW'(1);
                ovf_d   = OVF | evt;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            Q         <= '0;
            CNT       <= '0;
            OVF       <= 1'b0;
            DONE      <= 1'b0;
            FRAME_SUM <= '0;
            FRAME_OVF <= 1'b0;
        end else begin
            state     <= state_d;
            Q         <= q_d;
            CNT       <= cnt_d;
            OVF       <= ovf_d;
            DONE      <= done_d;
            FRAME_SUM <= fsum_d;
            FRAME_OVF <= fovf_d;
        end
    end

endmodule

// File: tb/tb_seq_frame_accumulator.sv
// Scoreboard bench: wrap and saturate instances share stimulus and are
// checked against an integer-arithmetic frame model.
module tb_seq_frame_accumulator;

    localparam int W  = 8;
    localparam int FR = 4;
    localparam int CW = $clog2(FR + 1);
    localparam int MX = (1 << W) - 1;

    typedef struct {
        int q;
        int cnt;
        bit ovf;
        bit done;
        int fs;
        bit fo;
    } mdl_t;

    logic          CLK = 0;
    logic          RST = 1;
    logic [W-1:0]  A = '0;
    logic          EN = 0;
    logic [1:0]    MODE = '0;
    logic          CLR = 0;

    logic [W-1:0]  q_w, fs_w, q_s, fs_s;
    logic [CW-1:0] cnt_w, cnt_s;
    logic          ovf_w, done_w, fo_w, ovf_s, done_s, fo_s;

    int checks = 0;
    int failures = 0;

    mdl_t mw, ms;
    mdl_t exp_w[$];
    mdl_t exp_s[$];
    int   fq_w[$];
    int   fq_s[$];

    always #5 CLK = ~CLK;

    seq_frame_accumulator #(.WIDTH(W), .FRAME(FR), .SATURATE(0)) dut_w (
        .CLK(CLK), .RST(RST), .A(A), .EN(EN), .MODE(MODE), .CLR(CLR),
        .Q(q_w), .CNT(cnt_w), .OVF(ovf_w), .DONE(done_w),
        .FRAME_SUM(fs_w), .FRAME_OVF(fo_w)
    );

    seq_frame_accumulator #(.WIDTH(W), .FRAME(FR), .SATURATE(1)) dut_s (
        .CLK(CLK), .RST(RST), .A(A), .EN(EN), .MODE(MODE), .CLR(CLR),
        .Q(q_s), .CNT(cnt_s), .OVF(ovf_s), .DONE(done_s),
        .FRAME_SUM(fs_s), .FRAME_OVF(fo_s)
    );

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, expv, $time);
        end
    endtask

    function automatic mdl_t mzero();
        mdl_t z;
        z.q = 0; z.cnt = 0; z.ovf = 0; z.done = 0; z.fs = 0; z.fo = 0;
        return z;
    endfunction

    // One clock edge of the frame accumulator, in plain integer arithmetic
    function automatic mdl_t mstep(mdl_t m, bit sat, bit rst, bit clr,
                                   bit en, logic [1:0] mode, int a);
        mdl_t n = m;
        int   r;
        bit   ev;
        n.done = 0;
        if (rst) return mzero();
        if (clr) begin
            n.q = 0; n.cnt = 0; n.ovf = 0;
            return n;
        end
        if (!en || mode == 2'b11) return n;
        ev = 0;
        if (mode == 2'b00) begin
            r = m.q + a;
            if (r > MX) begin ev = 1; r = sat ? MX : r - (MX + 1); end
        end else if (mode == 2'b01) begin
            r = m.q - a;
            if (r < 0) begin ev = 1; r = sat ? 0 : r + (MX + 1); end
        end else begin
            r = a;
        end
        if (m.cnt == FR - 1) begin
            n.fs = r; n.fo = m.ovf | ev;
            n.q = 0; n.cnt = 0; n.ovf = 0; n.done = 1;
        end else begin
            n.q = r; n.cnt = m.cnt + 1; n.ovf = m.ovf | ev;
        end
        return n;
    endfunction

    task automatic step(bit rst, bit clr, bit en, logic [1:0] mode,
                        logic [W-1:0] a);
        RST = rst; CLR = clr; EN = en; MODE = mode; A = a;
        @(posedge CLK);
        mw = mstep(mw, 0, rst, clr, en, mode, int'(a));
        ms = mstep(ms, 1, rst, clr, en, mode, int'(a));
        exp_w.push_back(mw);
        exp_s.push_back(ms);
        if (mw.done) fq_w.push_back(mw.fs);
        if (ms.done) fq_s.push_back(ms.fs);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_q_w"}, int'(q_w), 0);
        chk({tag, "_cnt_w"}, int'(cnt_w), 0);
        chk({tag, "_ovf_w"}, int'(ovf_w), 0);
        chk({tag, "_done_w"}, int'(done_w), 0);
        chk({tag, "_fs_w"}, int'(fs_w), 0);
        chk({tag, "_fo_w"}, int'(fo_w), 0);
        chk({tag, "_q_s"}, int'(q_s), 0);
        chk({tag, "_fs_s"}, int'(fs_s), 0);
        chk({tag, "_fo_s"}, int'(fo_s), 0);
    endtask

    // Reset raised between edges must clear outputs with no clock edge
    task automatic do_reset();
        @(negedge CLK);
        #1;
        RST = 1;
        #1;
        chk_zero("async_rst");
        mw = mzero();
        ms = mzero();
        step(1, 0, 1, 2'b00, W'($urandom_range(0, MX)));
        step(1, 0, 1, 2'b10, W'($urandom_range(0, MX)));
    endtask

    always @(negedge CLK) begin
        mdl_t e;
        if (exp_w.size() > 0) begin
            e = exp_w.pop_front();
            chk("q_w", int'(q_w), e.q);
            chk("cnt_w", int'(cnt_w), e.cnt);
            chk("ovf_w", int'(ovf_w), int'(e.ovf));
            chk("done_w", int'(done_w), int'(e.done));
            chk("fsum_w", int'(fs_w), e.fs);
            chk("fovf_w", int'(fo_w), int'(e.fo));
        end
        if (exp_s.size() > 0) begin
            e = exp_s.pop_front();
            chk("q_s", int'(q_s), e.q);
            chk("cnt_s", int'(cnt_s), e.cnt);
            chk("ovf_s", int'(ovf_s), int'(e.ovf));
            chk("done_s", int'(done_s), int'(e.done));
            chk("fsum_s", int'(fs_s), e.fs);
            chk("fovf_s", int'(fo_s), int'(e.fo));
        end
        if (done_w) begin
            if (fq_w.size() == 0) chk("frame_w_unexpected", 1, 0);
            else chk("frame_w", int'(fs_w), fq_w.pop_front());
        end
        if (done_s) begin
            if (fq_s.size() == 0) chk("frame_s_unexpected", 1, 0);
            else chk("frame_s", int'(fs_s), fq_s.pop_front());
        end
    end

    initial begin
        mw = mzero();
        ms = mzero();
        #1;
        chk_zero("init_rst");
        step(1, 0, 1, 2'b00, 8'd77);
        step(1, 0, 1, 2'b01, 8'd200);
        // frame of 1,2,4,8
        step(0, 0, 1, 2'b00, 8'd1);
        step(0, 0, 1, 2'b00, 8'd2);
        step(0, 0, 1, 2'b00, 8'd4);
        step(0, 0, 1, 2'b00, 8'd8);
        step(0, 0, 0, 2'b00, 8'd0);
        // wrap / saturate on add
        step(0, 0, 1, 2'b00, 8'd200);
        step(0, 0, 1, 2'b00, 8'd100);
        step(0, 0, 1, 2'b00, 8'd0);
        step(0, 0, 1, 2'b00, 8'd0);
        // load then underflowing subtract
        step(0, 0, 1, 2'b00, 8'd200);
        step(0, 0, 1, 2'b00, 8'd100);
        step(0, 0, 1, 2'b10, 8'd5);
        step(0, 0, 1, 2'b01, 8'd10);
        // hold, idle, load
        step(0, 0, 1, 2'b11, 8'd9);
        step(0, 0, 1, 2'b11, 8'd9);
        step(0, 0, 1, 2'b11, 8'd9);
        step(0, 0, 0, 2'b00, 8'd99);
        step(0, 0, 1, 2'b10, 8'h20);
        // clear mid-frame with a colliding sample, then async reset
        step(0, 1, 0, 2'b00, 8'd0);
        step(0, 0, 1, 2'b00, 8'd1);
        step(0, 0, 1, 2'b00, 8'd2);
        step(0, 1, 1, 2'b00, 8'd7);
        step(0, 0, 0, 2'b00, 8'd0);
        do_reset();
        // randomized traffic, including back-to-back frames
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0,
                     2'($urandom_range(0, 3)),
                     W'($urandom_range(0, MX)));
            end
        end
        step(0, 0, 0, 2'b00, 8'd0);
        @(negedge CLK);
        #1;
        chk("exp_queue_drained", exp_w.size() + exp_s.size(), 0);
        chk("frame_queue_drained", fq_w.size() + fq_s.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_frame_accumulator.md
# seq_frame_accumulator

Parametrised, frame-based running accumulator for unsigned sample streams. Supports add, subtract, load and hold modes, with selectable wrap or saturate arithmetic. Counts accepted samples and, every FRAME samples, captures the frame result, pulses DONE and restarts the running sum. It is the general-width, multi-mode successor to the fixed 8-bit sequence adder and feeds downstream frame-level consumers.

## Interface
- WIDTH, 8, width of operand A, running sum Q and FRAME_SUM; must be ≥ 2.
- FRAME, 8, number of accepted samples per frame; must be ≥ 1.
- SATURATE, 0, overflow policy: 0 wraps modulo 2^WIDTH, 1 clamps.
- Derived: CW = $clog2(FRAME+1).
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; one clock, asynchronous, active-high.
- A  in  WIDTH  unsigned sample/operand.
- EN  in  1  sample valid; a sample is accepted at a rising edge when EN=1 and MODE≠11.
- MODE  in  2  operation code: 00 add (Q+A), 01 subtract (Q−A), 10 load (Q←A), 11 hold.
- CLR  in  1  synchronous clear of the current frame.
- Q  out  WIDTH  running sum of the current frame.
- CNT  out  CW  number of samples accepted in the current frame, range 0..FRAME−1.
- OVF  out  1  sticky flag: an overflow or underflow occurred in the current frame.
- DONE  out  1  one-cycle pulse: a frame completed.
- FRAME_SUM  out  WIDTH  result of the last completed frame; held until the next completion.
- FRAME_OVF  out  1  OVF value of the last completed frame.

## Operation
- Control FSM has two states:
  - IDLE: CNT=0.
  - RUN: 0<CNT<FRAME.
  - IDLE→RUN on an accepted sample when FRAME>1.
  - RUN→IDLE on frame completion or CLR.
  - FRAME=1: the block stays in IDLE and every accepted sample completes a frame.
- Priority per edge: RST > CLR > accepted sample > no change.
- Arithmetic is computed at WIDTH+1 bits.
  - Add: a carry out sets an event; result is the low WIDTH bits (wrap) or 2^WIDTH−1 (saturate).
  - Subtract: a borrow (A>Q) sets an event; result is the low WIDTH bits (wrap) or 0 (saturate).
  - Load: never sets an event.
- An event sets OVF in the same edge that updates Q.
- Non-completing accepted sample: Q←result, CNT←CNT+1, OVF←OVF|event.
- Completing sample (CNT=FRAME−1):
  - FRAME_SUM←result and FRAME_OVF←OVF|event.
  - Q←0, CNT←0, OVF←0, DONE←1.
- DONE is 0 at every edge that does not complete a frame.
- MODE=11 with EN=1: Q, CNT and OVF unchanged; the sample is not counted.
- EN=0: Q, CNT and OVF unchanged; MODE and A are ignored.
- CLR=1:
  - Q←0, CNT←0, OVF←0, DONE←0.
  - A simultaneous sample is discarded.
  - FRAME_SUM and FRAME_OVF are retained.
- RST=1: all outputs go to 0 immediately, with no clock edge required, and stay 0 while RST is held.
- Reset values: Q=0, CNT=0, OVF=0, DONE=0, FRAME_SUM=0, FRAME_OVF=0.

## Timing
- Q, CNT and OVF reflect an accepted sample one cycle after its edge.
- Latency A→Q is 1 edge.
- DONE is high for exactly the one cycle following the completing edge.
- FRAME_SUM and FRAME_OVF change on the completing edge, so they are valid while DONE=1.
- Back-to-back frames are allowed: a sample accepted in the DONE cycle is the first sample of the next frame.
- No stall or backpressure: every sample with EN=1 and MODE≠11 is consumed.
- RST deasserting between edges: the first active edge is the next rising CLK.
- RST asserted mid-frame: the partial frame is lost, DONE is not pulsed, and FRAME_SUM is cleared.

## Test plan
All scenarios use WIDTH=8, FRAME=4 unless stated.
1. Reset: RST=1 asserted between edges → all outputs 0 before the next edge; they remain 0 while RST=1 regardless of EN and A.
2. Frame add, SATURATE=0: EN=1, MODE=00, A=1,2,4,8 on four edges → Q=1,3,7, then Q=0 and CNT=0; FRAME_SUM=15, FRAME_OVF=0; DONE=1 for one cycle only.
3. Wrap: add A=200, then 100 → Q=44, OVF=1; add 0, 0 → DONE, FRAME_SUM=44, FRAME_OVF=1, OVF=0 in the new frame.
4. Saturate, SATURATE=1: add 200, then 100 → Q=255, OVF=1; load A=5 (MODE=10), then subtract 10 → Q=0, OVF stays 1, DONE after the 4th sample with FRAME_SUM=0.
5. Hold and idle:
   - MODE=11 with EN=1 for 3 edges → Q and CNT unchanged.
   - EN=0 with MODE=00 and A=99 → no change.
   - Load A=0x20 → Q=0x20, CNT+1.
6. Clear and reset mid-frame:
   - After 1+2 (Q=3, CNT=2), CLR=1 with EN=1 and A=7 → Q=0, CNT=0, no DONE, FRAME_SUM keeps its previous value.
   - Then RST pulsed mid-cycle → FRAME_SUM=0 immediately.
